// File: rtl/memoria_dados_param.sv
// -----------------------------------------------------------------------------
// memoria_dados_param
// Single-port, byte-addressed data memory with byte-lane write mask.
//
// - After reset the array is cleared one word per cycle (INICIALIZANDO);
//   pronto rises once the last word has been zeroed, and the FSM then stays
//   in OCIOSO until the next reset.
// - Accepted reads return data one cycle later with a leitura_valida pulse.
//   dado_leitura holds its value between reads.
// - Misaligned or out-of-range requests are dropped and flagged one cycle
//   later on erro_acesso.
// - A request with both enables set is a write only.
//
// Optional feature (compile-time macro MEMORIA_PARIDADE_EN):
//   One even-parity bit is stored per word. It is recomputed over the merged
//   word on every write and cleared with the array. The input
//   injetar_erro_paridade inverts the stored bit of the word being written.
//   A read whose data does not match its stored parity raises erro_paridade
//   together with leitura_valida.
//   Without the macro there is no parity storage and no injection port,
//   and erro_paridade is tied low.
// -----------------------------------------------------------------------------
module memoria_dados_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 128
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    requisicao,
    input  logic                    permisao_escrita,
    input  logic                    permisao_leitura,
    input  logic [ADDR_WIDTH-1:0]   endereco,
    input  logic [DATA_WIDTH-1:0]   dado_escrita,
    input  logic [DATA_WIDTH/8-1:0] mascara_bytes,
`ifdef MEMORIA_PARIDADE_EN
    input  logic                    injetar_erro_paridade,
`endif
    output logic [DATA_WIDTH-1:0]   dado_leitura,
    output logic                    leitura_valida,
    output logic                    pronto,
    output logic                    erro_acesso,
    output logic                    erro_paridade
);

    // Number of byte lanes per word and the address bits that select a lane.
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF   = (NB > 1) ? $clog2(NB) : 0;
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Low address bits that must be zero for an aligned access.
    localparam logic [ADDR_WIDTH-1:0] MASCARA_OFF = ADDR_WIDTH'((1 << OFF) - 1);
    // One extra bit so that DEPTH = 2^ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   DEPTH_L     = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]      ULTIMO      = CNT_W'(DEPTH - 1);

    // FSM encoding.
    localparam logic [0:0] INICIALIZANDO = 1'b0;
    localparam logic [0:0] OCIOSO        = 1'b1;

`ifdef MEMORIA_PARIDADE_EN
    // Even parity over one stored word.
    function automatic logic f_paridade(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
`ifdef MEMORIA_PARIDADE_EN
    logic                  r_paridade [0:DEPTH-1];
    logic                  r_erro_paridade;
`endif
    logic [0:0]            r_estado;
    logic [CNT_W-1:0]      r_contador;
    logic                  r_pronto;
    logic                  r_leitura_valida;
    logic [DATA_WIDTH-1:0] r_dado_leitura;
    logic                  r_erro_acesso;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  w_aceito;
    logic                  w_desalinhado;
    logic                  w_fora;
    logic                  w_escrita;
    logic                  w_leitura;
    logic [ADDR_WIDTH-1:0] w_indice;
    logic [CNT_W-1:0]      w_idx;

    // Classify the incoming request: accepted, misaligned, out of range, read or write.
    always_comb begin
        w_aceito      = requisicao & r_pronto & (permisao_escrita | permisao_leitura);
        w_desalinhado = (endereco & MASCARA_OFF) != {ADDR_WIDTH{1'b0}};
        w_indice      = endereco >> OFF;
        w_fora        = {1'b0, w_indice} >= DEPTH_L;
        w_idx         = w_indice[CNT_W-1:0];
        // A write takes priority when both enables are set.
        w_escrita     = w_aceito & ~w_desalinhado & ~w_fora & permisao_escrita;
        w_leitura     = w_aceito & ~w_desalinhado & ~w_fora & permisao_leitura
                        & ~permisao_escrita;
    end

    // ------------------------------------------------------------------
    // Array write port (shared by the clear sequence and normal writes)
    // ------------------------------------------------------------------
    logic                  w_mem_we;
    logic [CNT_W-1:0]      w_mem_idx;
    logic [DATA_WIDTH-1:0] w_mem_dado;
    logic [DATA_WIDTH-1:0] w_palavra_atual;
`ifdef MEMORIA_PARIDADE_EN
    logic                  w_mem_par;
`endif

    // Select the word to write: zero during clear, lane-merged data otherwise.
    always_comb begin
        w_mem_we        = 1'b0;
        w_mem_idx       = {CNT_W{1'b0}};
        w_mem_dado      = {DATA_WIDTH{1'b0}};
        w_palavra_atual = r_mem[w_idx];
`ifdef MEMORIA_PARIDADE_EN
        w_mem_par       = 1'b0;
`endif
        if (r_estado == INICIALIZANDO) begin
            // Clear sequence: the data and parity defaults of zero are what is written.
            w_mem_we  = 1'b1;
            w_mem_idx = r_contador;
        end else if (w_escrita) begin
            w_mem_we  = 1'b1;
            w_mem_idx = w_idx;
            // Lanes with a zero mask bit keep their current contents.
            for (int k = 0; k < NB; k++) begin
                if (mascara_bytes[k]) begin
                    w_mem_dado[8*k +: 8] = dado_escrita[8*k +: 8];
                end else begin
                    w_mem_dado[8*k +: 8] = w_palavra_atual[8*k +: 8];
                end
            end
`ifdef MEMORIA_PARIDADE_EN
            w_mem_par = f_paridade(w_mem_dado) ^ injetar_erro_paridade;
`endif
        end else begin
            w_mem_we = 1'b0;
        end
    end

    // Array storage: the clear sequence rewrites every word after reset, so the array itself has no reset.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_dado;
        end
    end

`ifdef MEMORIA_PARIDADE_EN
    // Parity storage, updated in lockstep with the data array.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_paridade[w_mem_idx] <= w_mem_par;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    // Clear sequencing, read data capture and the one-cycle status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado         <= INICIALIZANDO;
            r_contador       <= {CNT_W{1'b0}};
            r_pronto         <= 1'b0;
            r_leitura_valida <= 1'b0;
            r_dado_leitura   <= {DATA_WIDTH{1'b0}};
            r_erro_acesso    <= 1'b0;
        end else begin
            r_leitura_valida <= w_leitura;
            r_erro_acesso    <= w_aceito & (w_desalinhado | w_fora);
            if (w_leitura) begin
                r_dado_leitura <= r_mem[w_idx];
            end
            case (r_estado)
                INICIALIZANDO: begin
                    if (r_contador == ULTIMO) begin
                        r_estado   <= OCIOSO;
                        r_pronto   <= 1'b1;
                        r_contador <= {CNT_W{1'b0}};
                    end else begin
                        r_contador <= r_contador + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                OCIOSO: begin
                    // OCIOSO is left only through reset.
                    r_estado <= OCIOSO;
                    r_pronto <= 1'b1;
                end
                default: begin
                    r_estado   <= INICIALIZANDO;
                    r_pronto   <= 1'b0;
                    r_contador <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef MEMORIA_PARIDADE_EN
    // Parity check on the word being read; the flag lines up with leitura_valida.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_erro_paridade <= 1'b0;
        end else begin
            r_erro_paridade <= w_leitura
                               & (f_paridade(r_mem[w_idx]) != r_paridade[w_idx]);
        end
    end

    assign erro_paridade = r_erro_paridade;
`else
    assign erro_paridade = 1'b0;
`endif

    assign dado_leitura   = r_dado_leitura;
    assign leitura_valida = r_leitura_valida;
    assign pronto         = r_pronto;
    assign erro_acesso    = r_erro_acesso;

endmodule

// File: doc/memoria_dados_param.md
MEMORIA_DADOS_PARAM -- requirements
Module: memoria_dados_param

Interface
REQ-001 Parameter DATA_WIDTH, 16, word width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter ADDR_WIDTH, 16, byte-address width.
REQ-003 Parameter DEPTH, 128, number of words; SHALL be at most 2^(ADDR_WIDTH - log2(DATA_WIDTH/8)).
REQ-004 clock  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 requisicao  in  1  request valid.
REQ-007 permisao_escrita  in  1  write enable; qualified by requisicao.
REQ-008 permisao_leitura  in  1  read enable; qualified by requisicao.
REQ-009 endereco  in  ADDR_WIDTH  byte address.
REQ-010 dado_escrita  in  DATA_WIDTH  write data.
REQ-011 mascara_bytes  in  DATA_WIDTH/8  byte-lane write mask; bit k gates dado_escrita[8k+7:8k].
REQ-012 dado_leitura  out  DATA_WIDTH  registered read data.
REQ-013 leitura_valida  out  1  one-cycle pulse: dado_leitura is valid.
REQ-014 pronto  out  1  memory accepts requests.
REQ-015 erro_acesso  out  1  one-cycle pulse: request rejected (misaligned or out of range).
REQ-016 erro_paridade  out  1  one-cycle pulse: parity mismatch on read (see Configuration).

Function
REQ-017 FSM states SHALL be INICIALIZANDO and OCIOSO; reset enters INICIALIZANDO.
REQ-018 INICIALIZANDO: one word per cycle zeroed, indices 0..DEPTH-1 by counter; pronto=0; after index DEPTH-1 is written, next state OCIOSO.
REQ-019 OCIOSO: pronto=1; FSM SHALL remain there until reset.
REQ-020 Request accepted only when requisicao=1, pronto=1 and at least one enable is 1; requests in INICIALIZANDO are ignored without error.
REQ-021 Word index = endereco >> log2(DATA_WIDTH/8); misaligned means endereco low log2(DATA_WIDTH/8) bits non-zero.
REQ-022 Misaligned or index >= DEPTH: access dropped, memory unchanged, no leitura_valida, erro_acesso=1 the following cycle.
REQ-023 Write: only lanes with mascara_bytes bit 1 updated at the accepting edge; mask all-zero is a legal no-op write.
REQ-024 Read latency 1: dado_leitura and leitura_valida=1 registered at the edge after acceptance; leitura_valida=0 otherwise.
REQ-025 dado_leitura SHALL hold its last value when leitura_valida=0.
REQ-026 Both enables set in one request: treated as write only; no leitura_valida.
REQ-027 Back-to-back requests every cycle SHALL be accepted; read of an address written the previous cycle SHALL return the new data.

Reset
REQ-028 reset_n=0 SHALL immediately force: dado_leitura=0, leitura_valida=0, pronto=0, erro_acesso=0, erro_paridade=0, init counter=0, state INICIALIZANDO.
REQ-029 Reset asserted mid-initialisation or mid-operation SHALL restart the full clear sequence after release; an in-flight read SHALL produce no leitura_valida.

Configuration
REQ-030 Macro MEMORIA_PARIDADE_EN defined: one parity bit per word = XOR of stored word, recomputed over the merged word on every write and 0 on clear.
REQ-031 With MEMORIA_PARIDADE_EN: input injetar_erro_paridade (in, 1) inverts the stored parity bit of the word written; read mismatch sets erro_paridade=1 in the same cycle as leitura_valida.
REQ-032 Without MEMORIA_PARIDADE_EN: no parity storage, no injetar_erro_paridade port, erro_paridade tied 0.

Verification
REQ-033 Release reset with DEPTH=128 -> pronto=0 for exactly 128 cycles, then 1; reads of 0..254 step 2 return 0x0000.
REQ-034 Write endereco=2k, dado_escrita=2k, mask 2'b11 for k=0..127, then read all -> each returns 2k one cycle after request.
REQ-035 Word 0x10 holds 0xABCD; write 0x1234 with mask 2'b01 -> readback 0xAB34.
REQ-036 Read endereco=3 -> erro_acesso pulse, no leitura_valida; read endereco=256 -> erro_acesso pulse; memory unchanged.
REQ-037 Assert reset_n=0 for 1 cycle during write sequence at k=50 -> all outputs 0 immediately, 128-cycle clear repeats, word 0x20 reads 0x0000.
REQ-038 MEMORIA_PARIDADE_EN: write 0x00FF to address 4 with injetar_erro_paridade=1, read -> leitura_valida=1, erro_paridade=1; rewrite without injection -> erro_paridade=0.
